add_result_accum: RTL

- Downstream consumer of the 9-bit registered adder output S.
- Accumulates FRAME_LEN consecutive sums into one wider frame total and presents it on a valid/ready output port.
- Applies backpressure to the adder stage through s_ready while a finished frame has not been taken.
- Provides a wrapping count of completed frames for bench and debug visibility.

---
 rtl/add_result_accum.sv | 96 +++++++++
 1 files changed

// File: rtl/add_result_accum.sv
// add_result_accum: accumulates FRAME_LEN adder sums into a frame total on a valid/ready port
// Optional ACC_PEAK_EN adds peak_out, the per-frame maximum accepted sample.
module add_result_accum #(
    parameter int DATA_W    = 9,
    parameter int FRAME_LEN = 16,
    parameter int ACC_W     = 13,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] s_in,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef ACC_PEAK_EN
    output logic [DATA_W-1:0] peak_out,
`endif
    output logic [CNT_W-1:0]  frame_cnt
);
    localparam int CW = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           r_state, w_next;
    logic [ACC_W-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic [ACC_W-1:0] w_acc;
    logic             w_accept, w_last;

    assign s_ready  = (r_state == ACCUM) && en;
    assign w_accept = s_valid && s_ready;
    assign w_last   = w_accept && (r_cnt == CW'(FRAME_LEN - 1));
    assign w_acc    = r_sum + ACC_W'(s_in);

    // next state: IDLE waits for en, ACCUM runs to the last sample, HOLD waits for the handshake
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = en ? ACCUM : IDLE;
            ACCUM:   w_next = w_last ? HOLD : ACCUM;
            HOLD:    w_next = out_ready ? (en ? ACCUM : IDLE) : HOLD;
            default: w_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // running sum, sample count and the registered frame result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum     <= '0;
            r_cnt     <= '0;
            acc_out   <= '0;
            out_valid <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (r_state == HOLD && out_ready) out_valid <= 1'b0;
            if (w_last) begin
                acc_out   <= w_acc;
                out_valid <= 1'b1;
                frame_cnt <= frame_cnt + CNT_W'(1);
                r_sum     <= '0;
                r_cnt     <= '0;
            end else if (w_accept) begin
                r_sum <= w_acc;
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

`ifdef ACC_PEAK_EN
    logic [DATA_W-1:0] r_max, w_max;

    assign w_max = (s_in > r_max) ? s_in : r_max;

    // per-frame running maximum, published with the frame total
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max    <= '0;
            peak_out <= '0;
        end else if (w_last) begin
            peak_out <= w_max;
            r_max    <= '0;
        end else if (w_accept) begin
            r_max <= w_max;
        end
    end
`endif
endmodule
